// File: rtl/inst_fetch_pkg.sv
// Shared bus-width defines, FSM encodings and buffer entry type for the instruction fetch unit.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define InstAddrBus 31:0
`define InstBus     31:0
`define ZeroWord    32'h0000_0000
`define Enable      1'b1
`endif

package inst_fetch_pkg;

  localparam logic [1:0] S_BOOT    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_BLOCK   = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  typedef enum logic [1:0] {
    BOOT    = S_BOOT,
    REQ     = S_REQ,
    BLOCK   = S_BLOCK,
    DISCARD = S_DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [`InstAddrBus] pc;
    logic [`InstBus]     inst;
  } fetch_entry_t;

  // Sequential fetch step; wraps naturally at the top of the address space.
  function automatic logic [`InstAddrBus] next_pc(input logic [`InstAddrBus] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Two-entry response buffer: the output slot seen by decode plus one skid entry
// that absorbs a response arriving while decode is stalled.
module fetch_buf
  import inst_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_in_valid,
  input  logic [`InstAddrBus] i_in_pc,
  input  logic [`InstBus]     i_in_inst,
  output logic [`InstAddrBus] o_if_pc,
  output logic [`InstBus]     o_if_inst,
  output logic                o_if_valid,
  output logic                o_skid_valid_nxt
);

  fetch_entry_t r_slot;
  fetch_entry_t r_skid;
  fetch_entry_t w_in;
  logic         r_slot_valid;
  logic         r_skid_valid;
  logic         w_skid_valid_nxt;

  assign w_in = '{pc: i_in_pc, inst: i_in_inst};

  // Exposed so the fetch FSM can stop issuing before the skid overflows.
  always_comb begin
    w_skid_valid_nxt = 1'b0;
    if (i_flush)
      w_skid_valid_nxt = 1'b0;
    else if (!i_stall)
      w_skid_valid_nxt = r_skid_valid & i_in_valid;
    else if (r_slot_valid)
      w_skid_valid_nxt = r_skid_valid | i_in_valid;
    else
      w_skid_valid_nxt = r_skid_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot       <= '{pc: `ZeroWord, inst: `ZeroWord};
      r_skid       <= '{pc: `ZeroWord, inst: `ZeroWord};
      r_slot_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      if (i_flush) begin
        r_slot_valid <= 1'b0;
      end else if (!i_stall) begin
        if (r_skid_valid) begin
          r_slot       <= r_skid;
          r_slot_valid <= 1'b1;
          if (i_in_valid)
            r_skid <= w_in;
        end else if (i_in_valid) begin
          r_slot       <= w_in;
          r_slot_valid <= 1'b1;
        end else begin
          r_slot_valid <= 1'b0;
        end
      end else begin
        if (!r_slot_valid && i_in_valid) begin
          r_slot       <= w_in;
          r_slot_valid <= 1'b1;
        end else if (r_slot_valid && i_in_valid) begin
          r_skid <= w_in;
        end
      end
    end
  end

  assign o_if_pc          = r_slot.pc;
  assign o_if_inst        = r_slot.inst;
  assign o_if_valid       = r_slot_valid;
  assign o_skid_valid_nxt = w_skid_valid_nxt;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory requester with branch redirect,
// wrong-path response discard and backpressure via the fetch_buf slot/skid pair.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [`InstAddrBus] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_flag,
  input  logic [`InstAddrBus] branch_target,
  output logic                mem_req,
  output logic [`InstAddrBus] mem_addr,
  input  logic                mem_ack,
  input  logic [`InstBus]     mem_rdata,
  output logic [`InstAddrBus] if_pc,
  output logic [`InstBus]     if_inst,
  output logic                if_valid
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [`InstAddrBus] r_pc;
  logic [`InstAddrBus] r_req_addr;
  logic [`InstAddrBus] w_issue_addr;
  logic                w_issue;
  logic                w_redirect;
  logic                w_mem_req;
  logic                w_flush;
  logic                w_deliver;
  logic                w_skid_full_nxt;

  assign w_flush   = branch_flag && (r_state != BOOT);
  assign w_deliver = (r_state == REQ) && (mem_ack == `Enable) && !branch_flag;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= BOOT;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = REQ;
      REQ: begin
        if (mem_ack && branch_flag)
          w_state_nxt = REQ;
        else if (mem_ack)
          w_state_nxt = w_skid_full_nxt ? BLOCK : REQ;
        else if (branch_flag)
          w_state_nxt = DISCARD;
      end
      DISCARD: if (mem_ack) w_state_nxt = REQ;
      BLOCK:   if (branch_flag || !stall) w_state_nxt = REQ;
      default: w_state_nxt = BOOT;
    endcase
  end

  // A redirect without an issue only retargets pc; the stale request keeps running.
  always_comb begin
    w_mem_req    = 1'b0;
    w_issue      = 1'b0;
    w_redirect   = 1'b0;
    w_issue_addr = r_pc;
    case (r_state)
      BOOT: w_issue = 1'b1;
      REQ: begin
        w_mem_req = `Enable;
        if (mem_ack && branch_flag) begin
          w_issue      = 1'b1;
          w_issue_addr = branch_target;
        end else if (mem_ack) begin
          w_issue = !w_skid_full_nxt;
        end else if (branch_flag) begin
          w_redirect = 1'b1;
        end
      end
      DISCARD: begin
        w_mem_req = `Enable;
        if (mem_ack) begin
          w_issue = 1'b1;
          if (branch_flag)
            w_issue_addr = branch_target;
        end else if (branch_flag) begin
          w_redirect = 1'b1;
        end
      end
      BLOCK: begin
        if (branch_flag) begin
          w_issue      = 1'b1;
          w_issue_addr = branch_target;
        end else if (!stall) begin
          w_issue = 1'b1;
        end
      end
      default: w_issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_addr <= `ZeroWord;
    end else if (w_issue) begin
      r_req_addr <= w_issue_addr;
      r_pc       <= next_pc(w_issue_addr);
    end else if (w_redirect) begin
      r_pc <= branch_target;
    end
  end

  assign mem_req  = w_mem_req && !rst;
  assign mem_addr = r_req_addr;

  fetch_buf u_buf (
    .clk              (clk),
    .rst              (rst),
    .i_stall          (stall),
    .i_flush          (w_flush),
    .i_in_valid       (w_deliver),
    .i_in_pc          (r_req_addr),
    .i_in_inst        (mem_rdata),
    .o_if_pc          (if_pc),
    .o_if_inst        (if_inst),
    .o_if_valid       (if_valid),
    .o_skid_valid_nxt (w_skid_full_nxt)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a behavioural memory with programmable latency
// feeds two instances (RESET_PC 0 and 0xFFFF_FFFC) driven in lock-step.
module tb_inst_fetch;

  localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;
  localparam logic [31:0] JUNK  = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_rdata1 = 32'h0;
  logic        mem_req, mem_req1;
  logic [31:0] mem_addr, mem_addr1;
  logic [31:0] if_pc, if_pc1, if_inst, if_inst1;
  logic        if_valid, if_valid1;

  logic        memEn = 1'b0;
  logic        forceAck = 1'b0;
  int          memLatency = 0;
  int          waitCnt = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] qPc[$];
  logic [31:0] qInst[$];
  logic [31:0] q1Pc[$];
  logic [31:0] q1Inst[$];

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .if_pc(if_pc),
    .if_inst(if_inst), .if_valid(if_valid)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .mem_req(mem_req1), .mem_addr(mem_addr1),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata1), .if_pc(if_pc1),
    .if_inst(if_inst1), .if_valid(if_valid1)
  );

  // Memory: ack is a one-cycle pulse launched on the falling edge.
  always begin
    @(negedge clk);
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (forceAck) begin
      mem_ack    = 1'b1;
      mem_rdata  = JUNK;
      mem_rdata1 = JUNK;
    end else if (memEn && !rst && mem_req) begin
      if (waitCnt >= memLatency) begin
        mem_ack    = 1'b1;
        mem_rdata  = mem_addr ^ MAGIC;
        mem_rdata1 = mem_addr1 ^ MAGIC;
        waitCnt    = 0;
      end else begin
        waitCnt++;
      end
    end
    if (rst || !memEn) waitCnt = 0;
  end

  // Consumer: records every slot taken by decode on the coming edge.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      qPc.delete(); qInst.delete(); q1Pc.delete(); q1Inst.delete();
    end else if (!stall && !branch_flag) begin
      if (if_valid) begin qPc.push_back(if_pc); qInst.push_back(if_inst); end
      if (if_valid1) begin q1Pc.push_back(if_pc1); q1Inst.push_back(if_inst1); end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic atSample();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    memEn = 1'b0; memLatency = 0; stall = 1'b0; branch_flag = 1'b0; forceAck = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    memEn = 1'b1;
  endtask

  task automatic waitQueue(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      #4;
      if (qPc.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    memEn = 1'b0; stall = 1'b0; branch_flag = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    atSample();
    checks++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_req: got %0b expected 0", mem_req); end
    checks++; if (mem_req1 !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_req_wrap: got %0b expected 0", mem_req1); end
    checks++; if (if_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_if_valid: got %0b expected 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset_if_pc: got %h expected 0", if_pc); end
    checks++; if (if_inst !== 32'h0) begin fails++; $display("[TB] FAIL reset_if_inst: got %h expected 0", if_inst); end
    checks++; if (mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    @(posedge clk); #1;
    rst = 1'b0; memEn = 1'b1; memLatency = 0;
    atSample();
    checks++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL boot_idle_cycle: got %0b expected 0", mem_req); end
    atSample();
    checks++; if (mem_req !== 1'b1) begin fails++; $display("[TB] FAIL boot_issue_req: got %0b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL boot_issue_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_addr1 !== 32'hFFFF_FFFC) begin fails++; $display("[TB] FAIL boot_issue_addr_wrap: got %h expected fffffffc", mem_addr1); end
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] exp;
    waitQueue(3, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL seq_timeout: got %0d deliveries expected 3", qPc.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        exp = 32'(i * 4);
        checks++; if (qPc[i] !== exp) begin fails++; $display("[TB] FAIL seq_pc%0d: got %h expected %h", i, qPc[i], exp); end
        checks++; if (qInst[i] !== (exp ^ MAGIC)) begin fails++; $display("[TB] FAIL seq_inst%0d: got %h expected %h", i, qInst[i], exp ^ MAGIC); end
      end
    end
  endtask

  task automatic test_wrap();
    checks++; if (q1Pc.size() < 3) begin fails++; $display("[TB] FAIL wrap_count: got %0d expected >=3", q1Pc.size()); end
    if (q1Pc.size() >= 3) begin
      checks++; if (q1Pc[0] !== 32'hFFFF_FFFC) begin fails++; $display("[TB] FAIL wrap_pc0: got %h expected fffffffc", q1Pc[0]); end
      checks++; if (q1Pc[1] !== 32'h0) begin fails++; $display("[TB] FAIL wrap_pc1: got %h expected 0", q1Pc[1]); end
      checks++; if (q1Pc[2] !== 32'h4) begin fails++; $display("[TB] FAIL wrap_pc2: got %h expected 4", q1Pc[2]); end
      checks++; if (q1Inst[0] !== (32'hFFFF_FFFC ^ MAGIC)) begin fails++; $display("[TB] FAIL wrap_inst0: got %h expected %h", q1Inst[0], 32'hFFFF_FFFC ^ MAGIC); end
      checks++; if (q1Inst[1] !== MAGIC) begin fails++; $display("[TB] FAIL wrap_inst1: got %h expected %h", q1Inst[1], MAGIC); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit seen;
    doReset();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      atSample();
      if (if_valid) seen = 1'b1;
    end
    stall = 1'b1;
    checks++; if (!seen) begin fails++; $display("[TB] FAIL stall_first_valid: got 0 expected 1"); end
    repeat (5) atSample();
    checks++; if (if_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_hold_valid: got %0b expected 1", if_valid); end
    checks++; if (if_pc !== 32'h0) begin fails++; $display("[TB] FAIL stall_hold_pc: got %h expected 0", if_pc); end
    checks++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL stall_block_req: got %0b expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h4) begin fails++; $display("[TB] FAIL stall_last_addr: got %h expected 4", mem_addr); end
    checks++; if (qPc.size() != 0) begin fails++; $display("[TB] FAIL stall_no_delivery: got %0d expected 0", qPc.size()); end
    stall = 1'b0;
    waitQueue(3, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL stall_drain_timeout: got %0d expected 3", qPc.size()); end
    if (ok) begin
      checks++; if (qPc[0] !== 32'h0) begin fails++; $display("[TB] FAIL stall_pc0: got %h expected 0", qPc[0]); end
      checks++; if (qPc[1] !== 32'h4) begin fails++; $display("[TB] FAIL stall_pc1: got %h expected 4", qPc[1]); end
      checks++; if (qInst[1] !== (32'h4 ^ MAGIC)) begin fails++; $display("[TB] FAIL stall_inst1: got %h expected %h", qInst[1], 32'h4 ^ MAGIC); end
      checks++; if (qPc[2] !== 32'h8) begin fails++; $display("[TB] FAIL stall_pc2: got %h expected 8", qPc[2]); end
    end
  endtask

  task automatic test_branch_pending();
    bit ok;
    bit moved;
    doReset();
    waitQueue(2, ok);
    memLatency = 3;
    checks++; if (!ok) begin fails++; $display("[TB] FAIL brp_setup_timeout: got %0d expected 2", qPc.size()); end
    @(posedge clk); #1;
    branch_flag = 1'b1; branch_target = 32'h100;
    @(posedge clk); #1;
    branch_flag = 1'b0;
    atSample();
    checks++; if (if_valid !== 1'b0) begin fails++; $display("[TB] FAIL brp_flush_valid: got %0b expected 0", if_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin fails++; $display("[TB] FAIL brp_discard_req: got %0b/%h expected 1/00000008", mem_req, mem_addr); end
    moved = 1'b0;
    for (int i = 0; i < 20 && !moved; i++) begin
      atSample();
      if (mem_addr !== 32'h8) moved = 1'b1;
    end
    memLatency = 0;
    checks++; if (mem_addr !== 32'h100) begin fails++; $display("[TB] FAIL brp_next_addr: got %h expected 100", mem_addr); end
    checks++; if (qPc.size() != 2) begin fails++; $display("[TB] FAIL brp_dropped: got %0d deliveries expected 2", qPc.size()); end
    waitQueue(4, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL brp_timeout: got %0d expected 4", qPc.size()); end
    if (ok) begin
      checks++; if (qPc[2] !== 32'h100) begin fails++; $display("[TB] FAIL brp_pc2: got %h expected 100", qPc[2]); end
      checks++; if (qInst[2] !== (32'h100 ^ MAGIC)) begin fails++; $display("[TB] FAIL brp_inst2: got %h expected %h", qInst[2], 32'h100 ^ MAGIC); end
      checks++; if (qPc[3] !== 32'h104) begin fails++; $display("[TB] FAIL brp_pc3: got %h expected 104", qPc[3]); end
    end
  endtask

  task automatic test_branch_ack();
    bit ok;
    bit hit;
    doReset();
    waitQueue(1, ok);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (mem_ack) begin
        hit = 1'b1;
        branch_flag = 1'b1;
        branch_target = 32'h200;
      end
    end
    checks++; if (!hit || mem_addr !== 32'h4) begin fails++; $display("[TB] FAIL bra_ack_on_4: got %0b/%h expected 1/00000004", hit, mem_addr); end
    @(posedge clk); #1;
    branch_flag = 1'b0;
    atSample();
    checks++; if (mem_addr !== 32'h200) begin fails++; $display("[TB] FAIL bra_next_addr: got %h expected 200", mem_addr); end
    checks++; if (mem_req !== 1'b1) begin fails++; $display("[TB] FAIL bra_next_req: got %0b expected 1", mem_req); end
    checks++; if (if_valid !== 1'b0) begin fails++; $display("[TB] FAIL bra_if_valid: got %0b expected 0", if_valid); end
    waitQueue(3, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL bra_timeout: got %0d expected 3", qPc.size()); end
    if (ok) begin
      checks++; if (qPc[1] !== 32'h200) begin fails++; $display("[TB] FAIL bra_pc1: got %h expected 200", qPc[1]); end
      checks++; if (qPc[2] !== 32'h204) begin fails++; $display("[TB] FAIL bra_pc2: got %h expected 204", qPc[2]); end
    end
  endtask

  task automatic test_reset_midreq();
    bit ok;
    doReset();
    waitQueue(2, ok);
    memLatency = 20;
    atSample();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin fails++; $display("[TB] FAIL mid_outstanding: got %0b/%h expected 1/00000008", mem_req, mem_addr); end
    @(posedge clk); #1;
    rst = 1'b1; memEn = 1'b0;
    atSample();
    checks++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_req: got %0b expected 0", mem_req); end
    @(posedge clk); #1;
    rst = 1'b0; forceAck = 1'b1; memLatency = 0;
    atSample();
    forceAck = 1'b0; memEn = 1'b1;
    checks++; if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL mid_boot_req: got %0b expected 0", mem_req); end
    waitQueue(2, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL mid_timeout: got %0d expected 2", qPc.size()); end
    if (ok) begin
      checks++; if (qPc[0] !== 32'h0) begin fails++; $display("[TB] FAIL mid_pc0: got %h expected 0", qPc[0]); end
      checks++; if (qInst[0] !== MAGIC) begin fails++; $display("[TB] FAIL mid_inst0: got %h expected %h", qInst[0], MAGIC); end
      checks++; if (qPc[1] !== 32'h4) begin fails++; $display("[TB] FAIL mid_pc1: got %h expected 4", qPc[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_branch_pending();
    test_branch_ack();
    test_reset_midreq();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
